// File: rtl/td4_prog_loader.sv
// Instruction-fetch stage for the TD4 core: byte-serial program loader into a
// 16-word store, registered {immediate, opcode} fetch, and run gating for the CPU.
module td4_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              load_end,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic [3:0]        immediate,
    output logic              run_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              load_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   fetch_q, fetch_d;
    logic                load_done_q, load_done_d;
    logic                wr_en;

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        load_done_d = 1'b0;
        wr_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d   = LOAD;
                    wr_addr_d = '0;
                end
            end
            LOAD: begin
                // A transfer in the same cycle as load_end is still written.
                if (wr_valid) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    if (wr_addr_q == ADDR_LAST) state_d = RUN;
                end
                if (load_end) state_d = RUN;
                load_done_d = (state_d == RUN);
            end
            RUN: begin
                if (load_req) begin
                    state_d   = LOAD;
                    wr_addr_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                wr_addr_d = '0;
            end
        endcase
        // Outside RUN the core sees 8'h00, i.e. the harmless ADD A,0.
        fetch_d = (state_d == RUN) ? mem_q[pc] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            fetch_q     <= '0;
            load_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            fetch_q     <= fetch_d;
            load_done_q <= load_done_d;
            if (wr_en) mem_q[wr_addr_q] <= wr_data;
        end
    end

    assign wr_ready  = (state_q == LOAD);
    assign run_en    = (state_q == RUN);
    assign wr_addr   = wr_addr_q;
    assign load_done = load_done_q;
    assign opcode    = fetch_q[3:0];
    assign immediate = fetch_q[7:4];

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: reset, full/stalled/early-end loads,
// reload from RUN and reset during a load.
module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       rst, load_req, load_end, wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] pc;
    logic [3:0] opcode, immediate;
    logic       run_en;
    logic [3:0] wr_addr;
    logic       load_done;

    int n_checks = 0;
    int n_fail   = 0;

    td4_prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .load_end  (load_end),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .pc        (pc),
        .opcode    (opcode),
        .immediate (immediate),
        .run_en    (run_en),
        .wr_addr   (wr_addr),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load_req = 1'b1; load_end = 1'b0; wr_valid = 1'b1;
        wr_data = 8'hFF; pc = 4'd0;

        // 1: reset dominates load_req / wr_valid
        tick(); tick();
        chk("rst_run_en",    {7'd0, run_en},    8'h00);
        chk("rst_wr_ready",  {7'd0, wr_ready},  8'h00);
        chk("rst_opcode",    {4'd0, opcode},    8'h00);
        chk("rst_imm",       {4'd0, immediate}, 8'h00);
        chk("rst_wr_addr",   {4'd0, wr_addr},   8'h00);
        chk("rst_load_done", {7'd0, load_done}, 8'h00);
        rst = 1'b0; load_req = 1'b0; wr_valid = 1'b0;
        tick();
        chk("idle_wr_ready", {7'd0, wr_ready},  8'h00);

        // 2: full back-to-back load 8'h10..8'h1F
        load_req = 1'b1; tick(); load_req = 1'b0;
        chk("load_wr_ready", {7'd0, wr_ready}, 8'h01);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_addr%0d", i), {4'd0, wr_addr}, 8'(i));
            wr_valid = 1'b1; wr_data = 8'h10 + 8'(i);
            tick();
            if (i < 15) chk($sformatf("full_done%0d", i), {7'd0, load_done}, 8'h00);
        end
        wr_valid = 1'b0;
        chk("full_wrap",      {4'd0, wr_addr},   8'h00);
        chk("full_done",      {7'd0, load_done}, 8'h01);
        chk("full_run_en",    {7'd0, run_en},    8'h01);
        chk("full_entry_f",   {immediate, opcode}, 8'h10);
        pc = 4'd3; tick();
        chk("full_done_once", {7'd0, load_done}, 8'h00);
        chk("full_pc3_op",    {4'd0, opcode},    8'h03);
        chk("full_pc3_imm",   {4'd0, immediate}, 8'h01);
        pc = 4'd15; tick();
        chk("full_pc15",      {immediate, opcode}, 8'h1F);

        // 3: stalled handshake, then readback
        load_req = 1'b1; tick(); load_req = 1'b0;
        chk("stall_run_en", {7'd0, run_en}, 8'h00);
        chk("stall_fetch0", {immediate, opcode}, 8'h00);
        chk("stall_addr0",  {4'd0, wr_addr}, 8'h00);
        wr_valid = 1'b1; wr_data = 8'h55; tick();
        wr_valid = 1'b0; wr_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i), {4'd0, wr_addr}, 8'h01);
        end
        wr_valid = 1'b1; wr_data = 8'h66; tick();
        chk("stall_addr2", {4'd0, wr_addr}, 8'h02);
        wr_valid = 1'b0; load_end = 1'b1; tick(); load_end = 1'b0;
        chk("stall_done",  {7'd0, load_done}, 8'h01);
        chk("stall_run",   {7'd0, run_en}, 8'h01);
        pc = 4'd1; tick(); chk("stall_rb1", {immediate, opcode}, 8'h66);
        pc = 4'd2; tick(); chk("stall_rb2", {immediate, opcode}, 8'h12);
        pc = 4'd0; tick(); chk("stall_rb0", {immediate, opcode}, 8'h55);

        // 4: early end after three bytes, from a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        load_req = 1'b1; tick(); load_req = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'hA1; tick();
        wr_data = 8'hB2; tick();
        wr_data = 8'hC3; load_end = 1'b1; tick();
        wr_valid = 1'b0; load_end = 1'b0;
        chk("early_run",  {7'd0, run_en},    8'h01);
        chk("early_done", {7'd0, load_done}, 8'h01);
        chk("early_addr", {4'd0, wr_addr},   8'h03);
        pc = 4'd2; tick();
        chk("early_pc2_op",  {4'd0, opcode},    8'h03);
        chk("early_pc2_imm", {4'd0, immediate}, 8'h0C);
        pc = 4'd5; tick(); chk("early_pc5", {immediate, opcode}, 8'h00);
        pc = 4'd0; tick(); chk("early_pc0", {immediate, opcode}, 8'hA1);

        // load_end and wr_valid have no effect in RUN
        load_end = 1'b1; wr_valid = 1'b1; wr_data = 8'h99; tick();
        load_end = 1'b0; wr_valid = 1'b0;
        chk("run_ignore_end",  {7'd0, run_en},    8'h01);
        chk("run_ignore_done", {7'd0, load_done}, 8'h00);
        chk("run_ignore_wr",   {immediate, opcode}, 8'hA1);

        // 5: reload from RUN; load_req inside LOAD does not restart
        load_req = 1'b1; tick(); load_req = 1'b0;
        chk("reload_run_en", {7'd0, run_en},    8'h00);
        chk("reload_op",     {4'd0, opcode},    8'h00);
        chk("reload_imm",    {4'd0, immediate}, 8'h00);
        chk("reload_ready",  {7'd0, wr_ready},  8'h01);
        load_req = 1'b1; wr_valid = 1'b1; wr_data = 8'h7E; tick();
        load_req = 1'b0; wr_valid = 1'b0;
        chk("reload_norestart", {4'd0, wr_addr}, 8'h01);
        load_end = 1'b1; tick(); load_end = 1'b0;
        chk("reload_run", {7'd0, run_en}, 8'h01);
        pc = 4'd0; tick();
        chk("reload_pc0_op",  {4'd0, opcode},    8'h0E);
        chk("reload_pc0_imm", {4'd0, immediate}, 8'h07);
        pc = 4'd1; tick(); chk("reload_pc1", {immediate, opcode}, 8'hB2);

        // 6: reset in the middle of a load discards everything
        load_req = 1'b1; tick(); load_req = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'hF0 + 8'(i); tick();
        end
        chk("midrst_addr7", {4'd0, wr_addr}, 8'h07);
        rst = 1'b1; tick(); rst = 1'b0; wr_valid = 1'b0;
        chk("midrst_ready", {7'd0, wr_ready}, 8'h00);
        chk("midrst_run",   {7'd0, run_en},   8'h00);
        chk("midrst_addr",  {4'd0, wr_addr},  8'h00);
        load_req = 1'b1; tick(); load_req = 1'b0;
        load_end = 1'b1; tick(); load_end = 1'b0;
        chk("midrst_run2", {7'd0, run_en}, 8'h01);
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i); tick();
            chk($sformatf("midrst_mem%0d", i), {immediate, opcode}, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
